// File: rtl/led_anim_seq_if.sv
// Control/upload bus and LED outputs for led_anim_seq.
// master = board control side, slave = the sequencer.
interface led_anim_seq_if #(
  parameter int LED_W  = 7,
  parameter int ADDR_W = 7,
  parameter int DIV_W  = 16
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LED_W-1:0]  wr_data;
  logic [LED_W-1:0]  led_n;
  logic [ADDR_W-1:0] frame;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, mode, div, len,
    output wr_en, wr_addr, wr_data,
    input  led_n, frame, busy, done
  );

  modport slave (
    input  start, stop, mode, div, len,
    input  wr_en, wr_addr, wr_data,
    output led_n, frame, busy, done
  );
endinterface

// File: rtl/led_anim_seq.sv
// LED animation sequencer: pattern RAM, prescaler, loop/one-shot/ping-pong.
// Ports: clk, rst (sync, active high), bus (led_anim_seq_if.slave).
module led_anim_seq #(
  parameter int LED_W  = 7,
  parameter int ADDR_W = 7,
  parameter int DIV_W  = 16
) (
  input logic           clk,
  input logic           rst,
  led_anim_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN_UP,
    RUN_DOWN
  } state_e;

  localparam logic [1:0] M_ONE = 2'b01;
  localparam logic [1:0] M_PP  = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] frame_q, frame_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DIV_W-1:0]  pc_q, pc_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic [LED_W-1:0]  led_n_q, led_n_d;
  logic [LED_W-1:0]  mem_q [2**ADDR_W];
  logic              tick;

  assign tick = (pc_q == div_q);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    len_d   = len_q;
    pc_d    = pc_q;
    div_d   = div_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    led_n_d = led_n_q;
    // The RAM is read only in the cycle after a frame is loaded, so a
    // write to the shown frame stays hidden until that frame comes round.
    if (state_q == IDLE) begin
      led_n_d = '1;
    end else if (rd_q) begin
      led_n_d = mem_q[frame_q];
    end
    if (bus.stop) begin
      state_d = IDLE;
      frame_d = '0;
      pc_d    = '0;
    end else if (bus.start) begin
      state_d = RUN_UP;
      frame_d = '0;
      pc_d    = '0;
      mode_d  = bus.mode;
      div_d   = bus.div;
      len_d   = bus.len;
      rd_d    = 1'b1;
    end else if (state_q != IDLE) begin
      if (!tick) begin
        pc_d = pc_q + DIV_W'(1);
      end else begin
        pc_d = '0;
        rd_d = 1'b1;
        priority case (1'b1)
          state_q == RUN_DOWN && frame_q != '0: begin
            frame_d = frame_q - ADDR_W'(1);
          end
          state_q == RUN_DOWN: begin
            state_d = RUN_UP;
            frame_d = ADDR_W'(1);
          end
          frame_q < len_q: begin
            frame_d = frame_q + ADDR_W'(1);
          end
          mode_q == M_ONE: begin
            state_d = IDLE;
            frame_d = '0;
            done_d  = 1'b1;
            rd_d    = 1'b0;
          end
          mode_q == M_PP && len_q != '0: begin
            state_d = RUN_DOWN;
            frame_d = len_q - ADDR_W'(1);
          end
          // loop, mode 11, or a single-frame ping-pong
          default: begin
            frame_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      len_q   <= '0;
      pc_q    <= '0;
      div_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      led_n_q <= '1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      led_n_q <= led_n_d;
    end
  end

  // Pattern RAM survives reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.led_n = led_n_q;
  assign bus.frame = frame_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_led_anim_seq.sv
// Self-checking bench for led_anim_seq.
// Expected {frame, led_n, busy, done} per cycle are queued, then compared.
module tb_led_anim_seq;
  typedef struct packed {
    logic [6:0] f;
    logic [6:0] led;
    logic       b;
    logic       d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  exp_t       sb[$];
  logic [6:0] pat [128];
  logic [6:0] last_f;
  logic       last_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  led_anim_seq_if bus ();

  led_anim_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // led_n must show the pattern of the previous cycle's frame while busy
  task automatic push_exp(input logic [6:0] f, input logic b,
                          input logic d);
    exp_t e;
    e.f   = f;
    e.led = last_b ? pat[last_f] : 7'h7f;
    e.b   = b;
    e.d   = d;
    sb.push_back(e);
    last_f = f;
    last_b = b;
  endtask

  task automatic write_pat(input logic [6:0] a, input logic [6:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    pat[a]    = d;
  endtask

  task automatic start_seq(input logic [1:0] m, input logic [15:0] dv,
                           input logic [6:0] l);
    bus.mode  = m;
    bus.div   = dv;
    bus.len   = l;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    got = {bus.frame, bus.led_n, bus.busy, bus.done};
    checks++;
    if (got !== {7'd0, 7'h7f, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_init got %h exp %h", got,
               {7'd0, 7'h7f, 1'b0, 1'b0});
    end
    for (int i = 0; i < 6; i++) write_pat(7'(i), ~(7'(1) << i));
    start_seq(2'b00, 16'd3, 7'd3);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== {7'd0, 7'h7f, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %h exp %h", k, got,
                 {7'd0, 7'h7f, 1'b0, 1'b0});
      end
      step();
    end
  endtask

  task automatic test_loop();
    exp_t e, got;
    int   k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b00, 16'd2, 7'd3);
    bus.div = 16'd0;
    bus.len = 7'd1;
    for (int i = 0; i < 24; i++) push_exp(7'((i / 3) % 4), 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL loop k=%0d got %h exp %h", k, got, e);
      end
      bus.stop = (k == 23);
      step();
      k++;
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_one_shot();
    exp_t e, got;
    int   k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b01, 16'd0, 7'd4);
    for (int i = 0; i < 5; i++) push_exp(7'(i), 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b1);
    push_exp(7'd0, 1'b0, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL one_shot k=%0d got %h exp %h", k, got, e);
      end
      step();
      k++;
    end
  endtask

  task automatic test_ping_pong();
    exp_t       e, got;
    int         k;
    logic [6:0] seq [6];
    seq = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd2, 7'd1};
    k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b10, 16'd0, 7'd3);
    for (int i = 0; i < 14; i++) push_exp(seq[i % 6], 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ping_pong k=%0d got %h exp %h", k, got, e);
      end
      bus.stop = (k == 13);
      step();
      k++;
    end
    bus.stop = 1'b0;
    k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b10, 16'd0, 7'd0);
    for (int i = 0; i < 8; i++) push_exp(7'd0, 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pp_len0 k=%0d got %h exp %h", k, got, e);
      end
      bus.stop = (k == 7);
      step();
      k++;
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_conflicts();
    exp_t e, got;
    int   k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b00, 16'd0, 7'd3);
    for (int i = 0; i < 3; i++) push_exp(7'(i), 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL start_stop k=%0d got %h exp %h", k, got, e);
      end
      bus.start = (k == 2);
      bus.stop  = (k == 2);
      step();
      k++;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b00, 16'd1, 7'd5);
    for (int i = 0; i < 5; i++) push_exp(7'(i / 2), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push_exp(7'(i % 3), 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL restart k=%0d got %h exp %h", k, got, e);
      end
      bus.start = (k == 4);
      bus.div   = 16'd0;
      bus.len   = 7'd2;
      bus.stop  = (k == 10);
      step();
      k++;
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_live_write();
    exp_t e, got;
    int   k = 0;
    last_f = '0;
    last_b = 1'b0;
    start_seq(2'b00, 16'd7, 7'd3);
    for (int i = 0; i < 9; i++) push_exp(7'((i / 8) % 4), 1'b1, 1'b0);
    pat[0] = 7'b0000000;
    for (int i = 9; i < 41; i++) push_exp(7'((i / 8) % 4), 1'b1, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    push_exp(7'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.frame, bus.led_n, bus.busy, bus.done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL live_write k=%0d got %h exp %h", k, got, e);
      end
      bus.wr_en   = (k == 0);
      bus.wr_addr = 7'd0;
      bus.wr_data = 7'b0000000;
      bus.stop    = (k == 40);
      step();
      k++;
    end
    bus.wr_en = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.mode    = 2'b00;
    bus.div     = '0;
    bus.len     = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    test_loop();
    test_one_shot();
    test_ping_pong();
    test_conflicts();
    test_live_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
